// File: rtl/l2_arbiter_if.sv
// L1-to-L2 arbiter bus: both L1 miss ports plus the shared L2 port.
// slave is the arbiter's view, master is the surrounding caches/L2.
interface l2_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [DATA_W-1:0] l2_wdata;
  logic [DATA_W-1:0] l2_rdata;
  logic              l2_ready;
  logic              busy;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_ready,
    output i_rdata, i_ready, d_rdata, d_ready, l2_read, l2_write, l2_addr, l2_wdata, busy
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_ready,
    input  i_rdata, i_ready, d_rdata, d_ready, l2_read, l2_write, l2_addr, l2_wdata, busy
  );
endinterface

// File: rtl/l2_arbiter.sv
// Round-robin arbiter serialising I-cache fills and D-cache fills/write-backs
// onto the single L2 port; one dead cycle follows every transfer.
module l2_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input logic          clk,
  input logic          rst,
  l2_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;
  typedef enum logic {REQ_I = 1'b0, REQ_D = 1'b1} req_t;

  state_t            state_q, state_d;
  req_t              last_q;
  logic              i_pend, d_pend;
  logic              grant_i, grant_d;
  logic              i_ready_c, d_ready_c;
  logic              l2_read_q, l2_write_q, busy_q;
  logic [ADDR_W-1:0] l2_addr_q;
  logic [DATA_W-1:0] l2_wdata_q;

  assign i_pend = bus.i_read;
  assign d_pend = bus.d_read | bus.d_write;

  always_comb begin
    state_d   = state_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    i_ready_c = 1'b0;
    d_ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the requester not served last wins.
        if (i_pend && d_pend) begin
          grant_d = (last_q == REQ_I);
          grant_i = ~grant_d;
        end else begin
          grant_i = i_pend;
          grant_d = d_pend;
        end
        if (grant_i)      state_d = GNT_I;
        else if (grant_d) state_d = GNT_D;
      end
      GNT_I: if (bus.l2_ready) begin
        i_ready_c = ~rst;
        state_d   = DONE;
      end
      GNT_D: if (bus.l2_ready) begin
        d_ready_c = ~rst;
        state_d   = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= REQ_I;
      busy_q     <= 1'b0;
      l2_read_q  <= 1'b0;
      l2_write_q <= 1'b0;
      l2_addr_q  <= '0;
      l2_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      if (grant_i) begin
        l2_read_q  <= 1'b1;
        l2_write_q <= 1'b0;
        l2_addr_q  <= bus.i_addr;
      end else if (grant_d) begin
        // Write-back takes precedence when both D op bits are set.
        l2_read_q  <= ~bus.d_write;
        l2_write_q <= bus.d_write;
        l2_addr_q  <= bus.d_addr;
        l2_wdata_q <= bus.d_wdata;
      end else if (state_d == DONE) begin
        l2_read_q  <= 1'b0;
        l2_write_q <= 1'b0;
        last_q     <= (state_q == GNT_D) ? REQ_D : REQ_I;
      end
    end
  end

  assign bus.i_rdata  = bus.l2_rdata;
  assign bus.d_rdata  = bus.l2_rdata;
  assign bus.i_ready  = i_ready_c;
  assign bus.d_ready  = d_ready_c;
  assign bus.l2_read  = l2_read_q;
  assign bus.l2_write = l2_write_q;
  assign bus.l2_addr  = l2_addr_q;
  assign bus.l2_wdata = l2_wdata_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: transaction-level model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_l2_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  l2_arbiter_if #(.ADDR_W(28), .DATA_W(128)) bus ();
  l2_arbiter #(.ADDR_W(28), .DATA_W(128)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic chkw(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Model: owner of the L2 port (0 none, 1 I, 2 D), dead cycles left before
  // arbitration resumes, and who was served last.
  int          m_owner = 0, m_gap = 0, m_last = 1;
  bit          m_rd = 0, m_wr = 0, armed = 0;
  logic [27:0] m_addr = '0;
  logic [127:0] m_wdata = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = 0; m_gap = 0; m_last = 1;
      m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
      armed = 1;
    end else if (m_owner != 0) begin
      if (bus.l2_ready) begin
        m_last = m_owner; m_owner = 0; m_rd = 0; m_wr = 0; m_gap = 1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      if (bus.i_read && (bus.d_read || bus.d_write)) m_owner = (m_last == 1) ? 2 : 1;
      else if (bus.i_read)                           m_owner = 1;
      else if (bus.d_read || bus.d_write)            m_owner = 2;
      if (m_owner == 1) begin
        m_rd = 1; m_wr = 0; m_addr = bus.i_addr;
      end else if (m_owner == 2) begin
        m_wr = bus.d_write; m_rd = !bus.d_write; m_addr = bus.d_addr; m_wdata = bus.d_wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk1("m_l2_read",  bus.l2_read,  m_rd);
      chk1("m_l2_write", bus.l2_write, m_wr);
      chkw("m_l2_addr",  128'(bus.l2_addr), 128'(m_addr));
      if (m_wr) chkw("m_l2_wdata", bus.l2_wdata, m_wdata);
      chk1("m_busy",     bus.busy, (m_owner != 0) || (m_gap > 0));
      chk1("m_i_ready",  bus.i_ready, !rst && m_owner == 1 && bus.l2_ready);
      chk1("m_d_ready",  bus.d_ready, !rst && m_owner == 2 && bus.l2_ready);
      chkw("m_i_rdata",  bus.i_rdata, bus.l2_rdata);
      chkw("m_d_rdata",  bus.d_rdata, bus.l2_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output int qcyc);
    bit ok = 0;
    qcyc = -1;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (bus.l2_read || bus.l2_write) begin
        ok = 1;
        qcyc = cyc;
      end else tick();
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL req_timeout: no L2 request within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  // Wait for the L2 request, answer it lat cycles later, and stop at the
  // negedge of the ready cycle so the caller can inspect the strobes.
  task automatic serve(input int lat, input logic [127:0] data, output int qcyc, output int rcyc);
    wait_req(qcyc);
    repeat (lat) tick();
    bus.l2_ready = 1'b1;
    bus.l2_rdata = data;
    rcyc = cyc;
    @(negedge clk);
  endtask

  task automatic end_ready();
    tick();
    bus.l2_ready = 1'b0;
  endtask

  initial begin
    int q, r, prev_r;
    logic [27:0] exp_a;
    bus.i_read = 1; bus.i_addr = 28'h0000111;
    bus.d_read = 1; bus.d_write = 0; bus.d_addr = 28'h0000222; bus.d_wdata = '0;
    bus.l2_ready = 0; bus.l2_rdata = '0;

    // Reset with both requesting; D must win the first tie afterwards.
    repeat (2) begin
      tick();
      @(negedge clk);
      chk1("rst_l2_read", bus.l2_read, 1'b0);
      chk1("rst_busy", bus.busy, 1'b0);
      chkw("rst_l2_addr", 128'(bus.l2_addr), 128'h0);
      chk1("rst_i_ready", bus.i_ready, 1'b0);
    end
    rst = 0;
    serve(0, 128'h1, q, r);
    chkw("first_tie_addr", 128'(bus.l2_addr), 128'h0000222);
    chk1("first_tie_d_ready", bus.d_ready, 1'b1);
    chk1("first_tie_i_ready", bus.i_ready, 1'b0);
    end_ready();
    bus.i_read = 0; bus.d_read = 0;
    repeat (3) tick();

    // Single I fill, with i_read left up one cycle past i_ready.
    bus.i_read = 1; bus.i_addr = 28'h0000040;
    serve(4, 128'hDEADBEEF, q, r);
    chk1("ifill_lat", (r - q) == 4, 1'b1);
    chkw("ifill_addr", 128'(bus.l2_addr), 128'h0000040);
    chk1("ifill_i_ready", bus.i_ready, 1'b1);
    chkw("ifill_rdata", bus.i_rdata, 128'hDEADBEEF);
    chk1("ifill_d_ready", bus.d_ready, 1'b0);
    end_ready();
    @(negedge clk);
    chk1("ifill_pulse", bus.i_ready, 1'b0);
    chk1("stale_busy_done", bus.busy, 1'b1);
    tick();
    bus.i_read = 0;
    repeat (3) tick();
    @(negedge clk);
    chk1("stale_no_grant", bus.l2_read, 1'b0);
    chk1("stale_idle", bus.busy, 1'b0);

    // Round-robin with both held: D, I, D, I and a 3-cycle turnaround.
    bus.i_read = 1; bus.i_addr = 28'h0000100;
    bus.d_read = 1; bus.d_addr = 28'h0000200;
    prev_r = -1;
    for (int k = 0; k < 4; k++) begin
      serve(2, 128'(k + 16), q, r);
      exp_a = (k % 2 == 0) ? 28'h0000200 : 28'h0000100;
      chkw("rr_addr", 128'(bus.l2_addr), 128'(exp_a));
      chk1("rr_d_ready", bus.d_ready, k % 2 == 0);
      chk1("rr_i_ready", bus.i_ready, k % 2 == 1);
      if (prev_r >= 0) chk1("rr_gap3", (q - prev_r) == 3, 1'b1);
      prev_r = r;
      end_ready();
    end
    bus.i_read = 0; bus.d_read = 0;
    repeat (3) tick();

    // D write-back with read also high.
    bus.d_read = 1; bus.d_write = 1; bus.d_addr = 28'h1234567;
    bus.d_wdata = {4{32'hA5A5A5A5}};
    serve(2, 128'h0, q, r);
    chk1("wb_write", bus.l2_write, 1'b1);
    chk1("wb_read", bus.l2_read, 1'b0);
    chkw("wb_wdata", bus.l2_wdata, {4{32'hA5A5A5A5}});
    chkw("wb_addr", 128'(bus.l2_addr), 128'h1234567);
    chk1("wb_d_ready", bus.d_ready, 1'b1);
    end_ready();
    bus.d_read = 0; bus.d_write = 0;
    @(negedge clk);
    chk1("wb_pulse", bus.d_ready, 1'b0);
    repeat (3) tick();

    // Reset during GNT_D aborts the write; D wins the first tie after.
    bus.d_read = 1; bus.d_write = 1; bus.d_addr = 28'h0003000;
    bus.d_wdata = 128'h0123456789ABCDEF;
    wait_req(q);
    chk1("mid_pre_write", bus.l2_write, 1'b1);
    rst = 1;
    bus.i_read = 1; bus.i_addr = 28'h0003100;
    tick();
    @(negedge clk);
    chk1("mid_write_drop", bus.l2_write, 1'b0);
    chk1("mid_no_d_ready", bus.d_ready, 1'b0);
    chk1("mid_busy", bus.busy, 1'b0);
    tick();
    rst = 0;
    serve(1, 128'h77, q, r);
    chkw("mid_tie_addr", 128'(bus.l2_addr), 128'h0003000);
    chk1("mid_tie_d_ready", bus.d_ready, 1'b1);
    end_ready();
    bus.i_read = 0; bus.d_read = 0; bus.d_write = 0;
    repeat (4) tick();
    @(negedge clk);
    chk1("final_idle", bus.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-requester arbiter sharing the single L2 cache port between the L1 instruction cache and the L1 data cache. It sits between both L1 miss-handling FSMs and the L2, and serialises their line transfers with round-robin priority. It returns per-requester ready strobes, which the L1 caches turn into the `CacheStall` seen by the hazard unit.

## Interface
- `ADDR_W`, 28, line address width (word address minus line offset)
- `DATA_W`, 128, line width in bits
- `clk  in  1  rising-edge clock`
- `rst  in  1  synchronous, active-high reset`
- `i_read  in  1  I-cache line-fill request`
- `i_addr  in  ADDR_W  I-cache line address`
- `i_rdata  out  DATA_W  fill data to I-cache`
- `i_ready  out  1  I-cache transfer complete strobe`
- `d_read  in  1  D-cache line-fill request`
- `d_write  in  1  D-cache write-back request`
- `d_addr  in  ADDR_W  D-cache line address`
- `d_wdata  in  DATA_W  D-cache write-back data`
- `d_rdata  out  DATA_W  fill data to D-cache`
- `d_ready  out  1  D-cache transfer complete strobe`
- `l2_read  out  1  read request to L2`
- `l2_write  out  1  write request to L2`
- `l2_addr  out  ADDR_W  line address to L2`
- `l2_wdata  out  DATA_W  write data to L2`
- `l2_rdata  in  DATA_W  read data from L2`
- `l2_ready  in  1  L2 transfer complete, valid for one cycle`
- `busy  out  1  high in any state except IDLE`

## Operation
- Requester I is pending when `i_read` is high. Requester D is pending when `d_read | d_write` is high.
- If `d_read` and `d_write` are both high, the D request is a write: `l2_write`=1, `l2_read`=0.
- FSM states:
  - IDLE
  - GNT_I
  - GNT_D
  - DONE
- IDLE, only one requester pending: grant it.
- IDLE, both pending: grant the one not in `last` (a 1-bit register holding the last-served requester). Reset value of `last` is I, so D wins the first tie.
- IDLE, none pending: stay in IDLE.
- On grant, register the request into the L2 output registers:
  - `l2_addr`, `l2_wdata` and the op bits are captured from the granted requester.
  - `l2_read`/`l2_write` hold steady for the whole GNT state.
  - Requester inputs changing during GNT are ignored.
- GNT_x with `l2_ready`=1:
  - `x_ready`=1 in that same cycle (combinational).
  - Next state is DONE; `last`<=x.
  - `l2_read`/`l2_write` clear at that edge.
- GNT_x with `l2_ready`=0: stay; no timeout.
- DONE: one dead cycle. Requests are ignored because the L1 request is still visible for one cycle after ready. Next state is IDLE.
- `i_rdata` and `d_rdata` are both wired to `l2_rdata` at all times. Only the ready strobe qualifies them.
- `i_ready` is forced to 0 outside GNT_I, `d_ready` is forced to 0 outside GNT_D, and `l2_ready` seen in IDLE/DONE is ignored.
- An I-side write is not supported; there is no port for it.

## Timing
- Reset values (next edge after `rst`=1):
  - state=IDLE, `last`=I
  - `l2_read`=`l2_write`=0, `l2_addr`=0, `l2_wdata`=0
  - `i_ready`=`d_ready`=0, `busy`=0
- Reset mid-transfer aborts it: L2 request lines drop at that edge and no ready strobe is produced.
- Request high in IDLE at cycle t: `l2_read`/`l2_write` high from t+1.
- `l2_ready` at cycle t+k:
  - ready strobe at t+k
  - DONE at t+k+1
  - IDLE at t+k+2; a pending request is granted there, so the next L2 request is high at t+k+3
- Minimum occupancy per transfer is 3 cycles (L2 answering in its first request cycle).
- Back-to-back simultaneous I and D streams alternate strictly I, D, I, D after the first D.
- `busy` is registered and equals (state != IDLE).

## Test plan
- Reset then idle: hold `rst`=1 for 2 cycles with `i_read`=`d_read`=1. Required: all outputs 0 during reset; first grant after release is D (`l2_addr`=`d_addr`).
- Single I fill: `i_read`=1, `i_addr`=28'h0000040; L2 returns `l2_ready` 4 cycles after `l2_read` rises, with `l2_rdata`=128'hDEADBEEF. Required: `l2_addr`=28'h0000040; `i_ready` pulses 1 cycle with `i_rdata`=128'hDEADBEEF; `d_ready` stays 0.
- D write-back with read also high: `d_read`=`d_write`=1, `d_wdata`=128'hA5A5…, `d_addr`=28'h1234567. Required: `l2_write`=1, `l2_read`=0; `l2_wdata` matches; `d_ready` is one pulse.
- Round-robin: both requests held high for 4 transfers with `l2_ready` after 2 cycles each. Required grant order D, I, D, I; exactly 3 cycles between a ready strobe and the next L2 request assertion.
- Stale request: the requester keeps `i_read` high for 1 cycle after `i_ready`, then drops it. Required: no second grant; state returns to IDLE; `busy`=0.
- Reset mid-op: assert `rst` during GNT_D before `l2_ready`. Required: `l2_write` low next cycle; no `d_ready`; first tie after release goes to D.
